// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the pipe_reg_chain delay line.
// PIPE_REG_PARITY_EN adds a parity bit to the per-stage control word.
package pipe_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PAR_MAX_W = 256;

  typedef struct packed {
    logic valid;
`ifdef PIPE_REG_PARITY_EN
    logic parity;
`endif
  } stage_ctl_t;

  function automatic int CNT_W(input int depth);
    int w;
    w = 1;
    while ((1 << w) < (depth + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: data word plus control word, sync active-low reset,
// flush clears valid only, active-low enable advances.
module pipe_stage
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             enable_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] data_in,
  input  stage_ctl_t       ctl_in,
  output logic [WIDTH-1:0] data_out,
  output stage_ctl_t       ctl_out
);

  logic [WIDTH-1:0] data_d, data_q;
  stage_ctl_t       ctl_d, ctl_q;

  // Next-state: flush beats advance, advance beats hold.
  always_comb begin
    data_d = data_q;
    ctl_d  = ctl_q;
    if (flush_in) begin
      data_d       = data_q;
      ctl_d        = ctl_q;
      ctl_d.valid  = 1'b0;
    end else if (!enable_in) begin
      data_d = data_in;
      ctl_d  = ctl_in;
    end else begin
      data_d = data_q;
      ctl_d  = ctl_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      data_q <= RESET_VAL;
      ctl_q  <= '0;
    end else begin
      data_q <= data_d;
      ctl_q  <= ctl_d;
    end
  end

  assign data_out = data_q;
  assign ctl_out  = ctl_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// WIDTH x DEPTH delay line with valid tracking, stall, flush and occupancy count.
// Optional PIPE_REG_PARITY_EN: per-stage even parity and sticky err_out.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    enable_in,
  input  logic                    flush_in,
  input  logic [WIDTH-1:0]        din_in,
  input  logic                    valid_in,
  output logic [WIDTH-1:0]        dout_out,
  output logic                    valid_out,
`ifdef PIPE_REG_PARITY_EN
  output logic                    err_out,
`endif
  output logic [CNT_W(DEPTH)-1:0] count_out
);

  localparam int CW = CNT_W(DEPTH);

  logic [WIDTH-1:0] stage_data_s [DEPTH];
  stage_ctl_t       stage_ctl_s  [DEPTH];
  stage_ctl_t       head_ctl_s;
  logic [CW:0]      count_sum_s;
  logic [CW-1:0]    count_d, count_q;

  // Control word entering stage 0.
  always_comb begin
    head_ctl_s       = '0;
    head_ctl_s.valid = valid_in;
`ifdef PIPE_REG_PARITY_EN
    begin
      logic [PAR_MAX_W-1:0] par_src_s;
      par_src_s             = '0;
      par_src_s[WIDTH-1:0]  = din_in;
      head_ctl_s.parity     = even_parity(par_src_s);
    end
`endif
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data_s;
    stage_ctl_t       in_ctl_s;
    if (i == 0) begin : g_head
      assign in_data_s = din_in;
      assign in_ctl_s  = head_ctl_s;
    end else begin : g_link
      assign in_data_s = stage_data_s[i-1];
      assign in_ctl_s  = stage_ctl_s[i-1];
    end
    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .enable_in (enable_in),
      .flush_in  (flush_in),
      .data_in   (in_data_s),
      .ctl_in    (in_ctl_s),
      .data_out  (stage_data_s[i]),
      .ctl_out   (stage_ctl_s[i])
    );
  end

  // Occupancy: widened add/subtract so the intermediate cannot wrap.
  always_comb begin
    count_sum_s = {1'b0, count_q}
                + {{CW{1'b0}}, valid_in}
                - {{CW{1'b0}}, stage_ctl_s[DEPTH-1].valid};
    if (flush_in) begin
      count_d = '0;
    end else if (!enable_in) begin
      count_d = count_sum_s[CW-1:0];
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef PIPE_REG_PARITY_EN
  logic                 err_d, err_q;
  logic [PAR_MAX_W-1:0] tail_src_s;

  // Sticky error on a valid last-stage item whose stored parity disagrees.
  always_comb begin
    tail_src_s            = '0;
    tail_src_s[WIDTH-1:0] = stage_data_s[DEPTH-1];
    if (stage_ctl_s[DEPTH-1].valid &&
        (stage_ctl_s[DEPTH-1].parity != even_parity(tail_src_s))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag survives flush; only reset clears it.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`endif

  assign dout_out  = stage_data_s[DEPTH-1];
  assign valid_out = stage_ctl_s[DEPTH-1].valid;
  assign count_out = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomized plus directed bench for pipe_reg_chain against a queue-based model.
module tb_pipe_reg_chain;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'hA5;

  logic       clk_in = 1'b0;
  logic       reset_in, enable_in, flush_in, valid_in;
  logic [7:0] din_in, dout_out;
  logic       valid_out;
  logic [2:0] count_out;
`ifdef PIPE_REG_PARITY_EN
  logic       err_out;
`endif

  always #5 clk_in = ~clk_in;

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .enable_in (enable_in),
    .flush_in  (flush_in),
    .din_in    (din_in),
    .valid_in  (valid_in),
    .dout_out  (dout_out),
    .valid_out (valid_out),
`ifdef PIPE_REG_PARITY_EN
    .err_out   (err_out),
`endif
    .count_out (count_out)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
  } item_t;

  item_t mdl[$];
  int    vec_cnt = 0;
  int    err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mdl_count();
    int n = 0;
    foreach (mdl[i]) if (mdl[i].v) n++;
    return n;
  endfunction

  task automatic check_outputs(input string when);
    check_eq({when, " dout"},  32'(dout_out),  32'(mdl[DEPTH-1].d));
    check_eq({when, " valid"}, 32'(valid_out), 32'(mdl[DEPTH-1].v));
    check_eq({when, " count"}, 32'(count_out), 32'(mdl_count()));
`ifdef PIPE_REG_PARITY_EN
    check_eq({when, " err"},   32'(err_out),   32'd0);
`endif
  endtask

  // One clock: drive at negedge, confirm nothing moves before the edge, then check after it.
  task automatic step(input logic rst, input logic en, input logic fl,
                      input logic [7:0] d, input logic v);
    @(negedge clk_in);
    reset_in  = rst;
    enable_in = en;
    flush_in  = fl;
    din_in    = d;
    valid_in  = v;
    #1;
    if (mdl.size() == DEPTH) check_outputs("pre");
    @(posedge clk_in);
    if (!rst) begin
      mdl = {};
      repeat (DEPTH) mdl.push_back('{d: RV, v: 1'b0});
    end else if (fl) begin
      foreach (mdl[i]) mdl[i].v = 1'b0;
    end else if (!en) begin
      mdl.push_front('{d: d, v: v});
      void'(mdl.pop_back());
    end
    #1;
    check_outputs("post");
  endtask

  initial begin
    reset_in = 1'b0; enable_in = 1'b1; flush_in = 1'b0; din_in = 8'h00; valid_in = 1'b0;

    // Reset then stream.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("reset dout", 32'(dout_out), 32'(RV));
    check_eq("reset count", 32'(count_out), 32'd0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 8'(i * 8'h11), 1'b1);
    check_eq("stream dout", 32'(dout_out), 32'h22);
    check_eq("stream count", 32'(count_out), 32'd4);

    // Stall with toggling input.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hF0 ^ 8'(i)), 1'(i[0]));
    check_eq("stall dout", 32'(dout_out), 32'h22);
    step(1'b1, 1'b0, 1'b0, 8'h66, 1'b1);
    check_eq("resume dout", 32'(dout_out), 32'h33);

    // Flush with a concurrent valid item.
    step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
    check_eq("flush count", 32'(count_out), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("no AA valid", 32'(valid_out && (dout_out == 8'hAA)), 32'd0);
    end

    // Bubbles.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, 8'(i), 1'(i[0]));
    check_eq("bubble count", 32'(count_out), 32'd2);
    check_eq("bubble valid", 32'(valid_out), 32'd1);

    // Reset mid-operation with three valid stages.
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h70 + 8'(i)), 1'b1);
    check_eq("pre-reset count", 32'(count_out), 32'd3);
    step(1'b0, 1'b0, 1'b0, 8'h99, 1'b1);
    check_eq("midreset count", 32'(count_out), 32'd0);
    check_eq("midreset dout", 32'(dout_out), 32'(RV));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 19) == 0),
           8'($urandom),
           1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
